// File: rtl/display_refresh_ctrl.sv
// display_refresh_ctrl: schedules 7-seg serializer start strobes (time updates, set steps, periodic
// refresh) and drives the blinking colon. Define SHIFT_TIMEOUT_EN to add the busy-handshake watchdog.
module display_refresh_ctrl #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int REFRESH_CYCLES = 5_000_000,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic       i_1hz_stb,
   input  logic       i_set_stb,
   input  logic       i_setting,
   input  logic       i_busy,
   output logic       o_start_stb,
   output logic       o_colon,
   output logic       o_pending,
   output logic       o_timeout_err,
   output logic [2:0] o_state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETTLE    = 3'd1,
      START     = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

   state_t          state_q;
   logic [ST_W-1:0] settle_cnt_q;
   logic            start_stb_q;
   logic            pending_q;
   logic            colon_q;
   logic            refresh_tick;
   logic            trigger;
   logic            timeout_hit;

   assign trigger = i_en & (i_1hz_stb | i_set_stb | refresh_tick);

   generate
      if (REFRESH_CYCLES > 0) begin : g_refresh
         localparam int RF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
         localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);
         logic [RF_W-1:0] refresh_cnt_q;
         logic [RF_W-1:0] refresh_cnt_d;
         logic            refresh_hit;

         assign refresh_hit = (refresh_cnt_q == RF_LAST);

         // Restart the period after every transfer so refreshes only fill quiet gaps.
         always_comb begin
            refresh_cnt_d = refresh_cnt_q + 1'b1;
            if (!i_en || start_stb_q || refresh_hit) begin
               refresh_cnt_d = '0;
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               refresh_cnt_q <= '0;
            end else begin
               refresh_cnt_q <= refresh_cnt_d;
            end
         end

         assign refresh_tick = i_en & refresh_hit;
      end else begin : g_no_refresh
         assign refresh_tick = 1'b0;
      end
   endgenerate

`ifdef SHIFT_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_err_q;
   logic            in_wait;

   assign in_wait = (state_q == WAIT_ACK) || (state_q == WAIT_DONE);

   // Abort fires on the edge where the count would reach TIMEOUT_CYCLES-1.
   assign timeout_hit = in_wait && (to_cnt_q == TO_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         if (state_q == START) begin
            to_cnt_q <= '0;
         end else if (in_wait) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (timeout_hit) begin
            timeout_err_q <= 1'b1;
         end
      end
   end

   assign o_timeout_err = timeout_err_q;
`else
   assign timeout_hit   = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   // Handshake: i_busy is a level from the serializer; after the strobe, WAIT_ACK holds until
   // busy is seen high, WAIT_DONE until it is seen low again.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         settle_cnt_q <= '0;
         start_stb_q  <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         start_stb_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trigger || (i_en && pending_q)) begin
                  state_q      <= SETTLE;
                  settle_cnt_q <= ST_LAST;
                  pending_q    <= 1'b0;
               end
            end
            SETTLE: begin
               if (!i_en) begin
                  state_q <= IDLE;
               end else if (trigger) begin
                  settle_cnt_q <= ST_LAST;
               end else if (settle_cnt_q == '0) begin
                  state_q     <= START;
                  start_stb_q <= 1'b1;
               end else begin
                  settle_cnt_q <= settle_cnt_q - 1'b1;
               end
            end
            START: begin
               state_q <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (timeout_hit) begin
                  state_q <= IDLE;
               end else if (i_busy) begin
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (timeout_hit || !i_busy) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
         if (trigger && (state_q == START || state_q == WAIT_ACK || state_q == WAIT_DONE)) begin
            pending_q <= 1'b1;
         end
         if (!i_en) begin
            pending_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         colon_q <= 1'b0;
      end else if (i_en && i_1hz_stb) begin
         colon_q <= ~colon_q;
      end
   end

   assign o_start_stb = start_stb_q;
   assign o_pending   = pending_q;
   assign o_colon     = i_setting | colon_q;
   assign o_state_dbg = state_q;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// Bench for display_refresh_ctrl: time-based reference model on the default instance, plus
// small instances for periodic refresh, disabled refresh and the busy watchdog.
module tb_display_refresh_ctrl;

   localparam int S    = 4;
   localparam int M_RP = 5_000_000;
   localparam int M_TO = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, hz, set_stb, setting, busy;
   logic       stb, colon, pend, err;
   logic [2:0] st;

   logic       a_rst, a_en, r_busy, t_hz;
   logic       r_stb, r_colon, r_pend, r_err;
   logic [2:0] r_st;
   logic       z_stb, z_colon, z_pend, z_err;
   logic [2:0] z_st;
   logic       t_stb, t_colon, t_pend, t_err;
   logic [2:0] t_st;

   int cyc      = 0;
   int n_cmp    = 0;
   int n_bad    = 0;
   int stb_cnt  = 0;
   int last_stb = -1;
   int z_cnt    = 0;
   int r_q[$];
   logic [31:0] exp_q[$];

   display_refresh_ctrl dut (
      .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_set_stb(set_stb),
      .i_setting(setting), .i_busy(busy), .o_start_stb(stb), .o_colon(colon),
      .o_pending(pend), .o_timeout_err(err), .o_state_dbg(st)
   );

   display_refresh_ctrl #(.REFRESH_CYCLES(100)) dut_r (
      .i_clk(clk), .i_reset(a_rst), .i_en(a_en), .i_1hz_stb(1'b0), .i_set_stb(1'b0),
      .i_setting(1'b0), .i_busy(r_busy), .o_start_stb(r_stb), .o_colon(r_colon),
      .o_pending(r_pend), .o_timeout_err(r_err), .o_state_dbg(r_st)
   );

   display_refresh_ctrl #(.REFRESH_CYCLES(0)) dut_z (
      .i_clk(clk), .i_reset(a_rst), .i_en(a_en), .i_1hz_stb(1'b0), .i_set_stb(1'b0),
      .i_setting(1'b0), .i_busy(1'b0), .o_start_stb(z_stb), .o_colon(z_colon),
      .o_pending(z_pend), .o_timeout_err(z_err), .o_state_dbg(z_st)
   );

   display_refresh_ctrl #(.REFRESH_CYCLES(0), .TIMEOUT_CYCLES(16)) dut_t (
      .i_clk(clk), .i_reset(a_rst), .i_en(a_en), .i_1hz_stb(t_hz), .i_set_stb(1'b0),
      .i_setting(1'b0), .i_busy(1'b0), .o_start_stb(t_stb), .o_colon(t_colon),
      .o_pending(t_pend), .o_timeout_err(t_err), .o_state_dbg(t_st)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   // Reference model: a transfer is a deadline (strobe edge = accept edge + S) followed by a
   // busy rise/fall; requests arriving after the strobe collapse into one pending flag.
   int m_due = -1, m_refresh = 0, m_stb_cyc = 0;
   bit m_stb, m_xfer, m_acked, m_pend, m_colon, m_err, m_valid;

   initial begin : model
      bit trig, rtick, was_stb, was_xfer;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         if (rst) begin
            m_due = -1; m_refresh = 0; m_stb = 0; m_xfer = 0; m_acked = 0;
            m_pend = 0; m_colon = 0; m_err = 0; m_valid = 1;
            exp_q.delete();
         end else begin
            rtick    = (M_RP > 0) && (m_refresh == M_RP - 1);
            trig     = en && (hz || set_stb || rtick);
            was_stb  = m_stb;
            was_xfer = m_xfer;
            m_refresh = (!en || was_stb || rtick) ? 0 : m_refresh + 1;
            if (en && hz) m_colon = !m_colon;
            m_stb = 0;
            if (m_due >= 0) begin
               if (!en) m_due = -1;
               else if (trig) m_due = cyc + S;
               else if (cyc == m_due) begin
                  m_stb = 1; m_due = -1; m_stb_cyc = cyc;
                  exp_q.push_back(cyc);
               end
            end else if (was_stb) begin
               m_xfer = 1; m_acked = 0;
            end else if (m_xfer) begin
`ifdef SHIFT_TIMEOUT_EN
               if (cyc == m_stb_cyc + M_TO) begin
                  m_xfer = 0; m_err = 1;
               end else
`endif
               if (!m_acked) m_acked = busy;
               else if (!busy) m_xfer = 0;
            end else if (trig || (en && m_pend)) begin
               m_due = cyc + S; m_pend = 0;
            end
            if (trig && (was_stb || was_xfer)) m_pend = 1;
            if (!en) m_pend = 0;
         end
      end
   end

   initial begin : compare
      int exp_st;
      logic [31:0] exp_c;
      forever begin
         @(negedge clk);
         if (stb === 1'b1) begin
            stb_cnt++;
            last_stb = cyc;
            exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk("stb_sched", cyc, exp_c);
         end
         if (r_stb === 1'b1) r_q.push_back(cyc);
         if (z_stb === 1'b1) z_cnt++;
         if (m_valid) begin
            exp_st = (m_due >= 0) ? 1 : m_stb ? 2 : (m_xfer && !m_acked) ? 3 : m_xfer ? 4 : 0;
            chk("m_start", stb, m_stb);
            chk("m_pending", pend, m_pend);
            chk("m_colon", colon, setting | m_colon);
            chk("m_err", err, m_err);
            chk("m_state", st, exp_st);
         end
      end
   end

   initial begin : r_handshake
      r_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (r_stb === 1'b1) begin
            @(posedge clk); #2; r_busy = 1'b1;
            @(posedge clk); #2; r_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic pulse_hz();
      hz = 1'b1; step(1); hz = 1'b0;
   endtask

   task automatic handshake();
      busy = 1'b1; step(2); busy = 1'b0; step(2);
   endtask

   task automatic await_strobe(input string name, input int max_cyc);
      int  n0;
      bit  seen;
      n0 = stb_cnt; seen = 0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         step(1);
         if (stb_cnt != n0) seen = 1;
      end
      chk(name, seen, 1);
   endtask

   initial begin : stim
      int t0, n0, f, s;
      rst = 1; a_rst = 1; en = 0; a_en = 0; hz = 0; set_stb = 0; setting = 0; busy = 0; t_hz = 0;
      step(3);
      chk("rst_start", stb, 0);
      chk("rst_colon", colon, 0);
      chk("rst_pending", pend, 0);
      chk("rst_err", err, 0);
      chk("rst_state", st, 0);
      rst = 0; a_rst = 0; en = 1; a_en = 1;
      step(5);

      // single seconds tick: colon next cycle, strobe 5 cycles after the tick
      t0 = cyc; n0 = stb_cnt;
      pulse_hz();
      chk("t1_colon", colon, 1);
      step(8);
      chk("t1_count", stb_cnt - n0, 1);
      chk("t1_latency", last_stb - t0, 5);
      handshake();

      // set step during SETTLE restarts the window
      t0 = cyc; n0 = stb_cnt;
      pulse_hz();
      step(2);
      set_stb = 1; step(1); set_stb = 0;
      step(6);
      chk("t2_count", stb_cnt - n0, 1);
      chk("t2_latency", last_stb - t0, 8);
      chk("t2_pending", pend, 0);
      handshake();

      // two ticks during a long busy collapse into one queued refresh
      t0 = cyc; n0 = stb_cnt;
      pulse_hz();
      step(5);
      busy = 1;
      step(4);
      pulse_hz();
      step(3);
      pulse_hz();
      chk("t3_pending_set", pend, 1);
      step(11);
      busy = 0; f = cyc;
      step(8);
      chk("t3_count", stb_cnt - n0, 2);
      chk("t3_requeue_lat", last_stb - f, 6);
      chk("t3_pending_clr", pend, 0);
      handshake();

      // colon forced while setting
      pulse_hz();
      await_strobe("t4_strobe", 10);
      handshake();
      setting = 1; step(1);
      chk("t4_colon_set", colon, 1);
      setting = 0; #1;
      chk("t4_colon_ff", colon, 0);

      // simultaneous tick and set step: one transfer, one toggle
      t0 = cyc; n0 = stb_cnt;
      hz = 1; set_stb = 1; step(1); hz = 0; set_stb = 0;
      chk("t5_colon", colon, 1);
      step(8);
      chk("t5_count", stb_cnt - n0, 1);
      chk("t5_latency", last_stb - t0, 5);
      handshake();

      // disable during SETTLE aborts without a strobe; ticks ignored while disabled
      n0 = stb_cnt;
      pulse_hz();
      step(1);
      en = 0;
      step(1);
      chk("t6_state", st, 0);
      chk("t6_pending", pend, 0);
      pulse_hz();
      step(8);
      chk("t6_count", stb_cnt - n0, 0);
      chk("t6_colon", colon, 0);
      en = 1; step(2);

      // disable drops a queued request but lets the transfer finish
      n0 = stb_cnt;
      pulse_hz();
      step(5);
      busy = 1;
      pulse_hz();
      chk("t7_pending_set", pend, 1);
      en = 0; step(1);
      chk("t7_pending_clr", pend, 0);
      busy = 0; step(3);
      chk("t7_state", st, 0);
      step(8);
      chk("t7_count", stb_cnt - n0, 1);
      en = 1; step(2);

      // reset mid-settle: no strobe
      n0 = stb_cnt;
      pulse_hz();
      step(2);
      rst = 1; step(1); rst = 0;
      step(8);
      chk("t8_count", stb_cnt - n0, 0);
      chk("t8_state", st, 0);
      chk("t8_colon", colon, 0);

      // periodic refresh instances
      step(350);
      chk("r_count_ge3", (r_q.size() >= 3), 1);
      if (r_q.size() >= 3) begin
         chk("r_gap1", r_q[1] - r_q[0], 105);
         chk("r_gap2", r_q[2] - r_q[1], 105);
      end
      chk("z_count", z_cnt, 0);

      // busy never answers
      t0 = cyc;
      t_hz = 1; step(1); t_hz = 0;
      step(3);
      chk("to_stb_early", t_stb, 0);
      step(1);
      chk("to_stb", t_stb, 1);
      s = cyc;
      step(15);
      chk("to_wait15", t_st, 3);
      step(1);
`ifdef SHIFT_TIMEOUT_EN
      chk("to_state16", t_st, 0);
      chk("to_err16", t_err, 1);
      step(20);
      chk("to_err_sticky", t_err, 1);
      chk("to_state_idle", t_st, 0);
`else
      chk("to_state16", t_st, 3);
      chk("to_err16", t_err, 0);
      step(20);
      chk("to_err_tied", t_err, 0);
      chk("to_state_hold", t_st, 3);
`endif
      chk("to_elapsed", cyc - s, 36);
      a_rst = 1; step(1); a_rst = 0;
      chk("to_err_rst", t_err, 0);
      chk("to_state_rst", t_st, 0);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_refresh_ctrl.md
Name: display_refresh_ctrl

Overview:
Sequencer for the 7-segment serial output path. Decides when the serializer's start strobe fires: on time updates, set-mode steps and a periodic refresh. Delays each start until the BCD/7-seg pipeline settles, tracks the serializer busy handshake, and queues one pending refresh. Also generates the blinking minutes colon. Sits between the clock strobe generator/clock register and the output serializer.

Parameters:
SETTLE_CYCLES, 4, cycles between a trigger and the start strobe (≥1); covers BCD/7-seg pipeline latency
REFRESH_CYCLES, 5_000_000, period of the forced refresh in i_clk cycles; 0 disables periodic refresh
TIMEOUT_CYCLES, 1024, busy-handshake watchdog limit (used only with SHIFT_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock; one clock, all logic on its rising edge
i_reset  in  1  reset; synchronous, active-high
i_en  in  1  display enable; low blocks new starts
i_1hz_stb  in  1  one-cycle seconds-tick strobe
i_set_stb  in  1  one-cycle time-set step strobe
i_setting  in  1  high while hours or minutes set is held (debounced)
i_busy  in  1  serializer busy
o_start_stb  out  1  one-cycle start strobe to serializer
o_colon  out  1  minutes colon decimal points
o_pending  out  1  a refresh is queued behind the current transfer
o_timeout_err  out  1  sticky handshake-timeout flag

Behaviour:
- Reset (i_reset high at a clock edge): state IDLE; o_start_stb=0, o_colon=0, o_pending=0, o_timeout_err=0; settle, refresh and timeout counters = 0.
- trigger = i_en & (i_1hz_stb | i_set_stb | refresh_tick).
- States: IDLE, SETTLE, START, WAIT_ACK, WAIT_DONE.
- IDLE: trigger or o_pending (with i_en=1) -> SETTLE; settle counter loads SETTLE_CYCLES-1; o_pending clears.
- SETTLE: counter decrements each cycle. At 0 -> START. A trigger in SETTLE reloads the counter to SETTLE_CYCLES-1 and does not set pending.
- START: o_start_stb=1 for exactly this cycle. Always -> WAIT_ACK.
- WAIT_ACK: i_busy=1 -> WAIT_DONE.
- WAIT_DONE: i_busy=0 -> IDLE.
- Latency: trigger sampled in IDLE at cycle T -> o_start_stb high at T+SETTLE_CYCLES+1. Default = 5 cycles.
- Pending:
  - A trigger in START, WAIT_ACK or WAIT_DONE sets o_pending.
  - Multiple triggers collapse into one pending request.
  - Pending is serviced on the first IDLE cycle, giving exactly one more transfer.
- i_en low:
  - No new triggers; o_pending clears.
  - A transfer already in SETTLE returns to IDLE without a strobe.
  - A transfer in START or WAIT_* completes normally.
- Refresh timer:
  - Increments each cycle while i_en=1; clears on every o_start_stb and while i_en=0.
  - refresh_tick pulses when the count reaches REFRESH_CYCLES-1; the counter then wraps to 0.
  - REFRESH_CYCLES=0: refresh_tick is never generated.
- Colon:
  - colon_ff toggles on each i_1hz_stb while i_en=1.
  - o_colon = i_setting ? 1 : colon_ff, combinational from registered terms.
  - i_1hz_stb and i_set_stb in the same cycle give one trigger and one colon toggle.
- Reset mid-transfer: the FSM returns to IDLE immediately and no strobe is issued. The serializer is reset by the same reset.

Optional Feature:
SHIFT_TIMEOUT_EN
- Defined:
  - A timeout counter clears on entering WAIT_ACK and increments in WAIT_ACK and WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1: FSM -> IDLE, o_timeout_err set (sticky until reset); o_pending is kept.
- Undefined: no counter; WAIT_ACK and WAIT_DONE wait indefinitely; o_timeout_err tied 0.

Test Plan:
- Defaults, reset then i_en=1, single i_1hz_stb at cycle 10 -> o_start_stb high only at cycle 15; o_colon goes 0->1 at cycle 11.
- Extra i_set_stb at cycle 13 (SETTLE) -> strobe moves to cycle 18; o_pending stays 0.
- i_busy held high 20 cycles after strobe; two i_1hz_stb during busy -> o_pending=1. After busy falls, exactly one more o_start_stb, at busy-fall+SETTLE_CYCLES+2; o_pending=0.
- REFRESH_CYCLES=100, no strobes, i_busy pulses 1 cycle after each start -> o_start_stb spaced by the refresh period plus handshake/settle latency, repeating. REFRESH_CYCLES=0 -> no strobes.
- i_setting=1 -> o_colon=1 regardless of colon_ff. i_en=0 during SETTLE -> no strobe, FSM back to IDLE, o_pending=0.
- With SHIFT_TIMEOUT_EN and TIMEOUT_CYCLES=16, i_busy never asserts -> FSM back to IDLE 16 cycles after the strobe, o_timeout_err=1 until i_reset. Without the macro -> FSM stays in WAIT_ACK, o_timeout_err=0.
